// File: rtl/sc_config_pkg.sv
// rtl/sc_config_pkg.sv - shared types and word indices for the scaler config commit path
package sc_config_pkg;

  localparam int unsigned NUM_CFG_REGS = 12;

  // Word positions inside the flattened config bus
  localparam int unsigned CFG_HV_IN  = 0;
  localparam int unsigned CFG_HV_OUT = 1;
  localparam int unsigned CFG_XY_OUT = 2;
  localparam int unsigned CFG_MISC0  = 3;
  localparam int unsigned CFG_MISC1  = 4;
  localparam int unsigned CFG_MISC2  = 5;
  localparam int unsigned CFG_MISC3  = 6;
  localparam int unsigned CFG_MISC4  = 7;
  localparam int unsigned CFG_SL0    = 8;
  localparam int unsigned CFG_SL1    = 9;
  localparam int unsigned CFG_SL2    = 10;
  localparam int unsigned CFG_SL3    = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } commit_state_t;

  typedef logic [31:0] cfg_word_t;

endpackage

// File: rtl/sc_config_commit_ctrl.sv
// rtl/sc_config_commit_ctrl.sv - frame-synchronous atomic commit of scaler config words
module sc_config_commit_ctrl
  import sc_config_pkg::*;
#(
  parameter int unsigned NUM_REGS       = NUM_CFG_REGS,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned TIMEOUT_W      = 21
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [32*NUM_REGS-1:0]   cfg_i,
  input  logic                     commit_req_i,
  input  logic                     frame_start_i,
  output logic [32*NUM_REGS-1:0]   cfg_o,
  output logic                     busy_o,
  output logic                     commit_done_o,
  output logic                     timeout_o,
  output logic                     coalesced_o,
  output logic [7:0]               commit_cnt_o
);

  // Counter value seen in the last ARMED cycle before a forced apply
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);

  commit_state_t        state_q;
  cfg_word_t            stage_q [NUM_REGS];
  cfg_word_t            cfg_q   [NUM_REGS];
  logic [TIMEOUT_W-1:0] to_cnt_q;
  logic                 to_hit;

  assign to_hit = TO_EN && (to_cnt_q == TO_LAST);
  assign busy_o = (state_q == ARMED);

  // Flatten the shadow words back onto the datapath bus
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign cfg_o[32*g +: 32] = cfg_q[g];
  end

  // Commit FSM: snapshot on request, apply staged words on frame start or timeout
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      to_cnt_q      <= '0;
      commit_done_o <= 1'b0;
      timeout_o     <= 1'b0;
      coalesced_o   <= 1'b0;
      commit_cnt_o  <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        stage_q[k] <= '0;
        cfg_q[k]   <= '0;
      end
    end else begin
      commit_done_o <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          // A frame start alongside the request is ignored: the apply waits a full frame
          if (commit_req_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              stage_q[k] <= cfg_i[32*k +: 32];
            end
            state_q     <= ARMED;
            to_cnt_q    <= '0;
            timeout_o   <= 1'b0;
            coalesced_o <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        ARMED: begin
          // Counter keeps running across coalesced requests so latency stays bounded
          to_cnt_q <= to_cnt_q + 1'b1;
          if (commit_req_i) begin
            coalesced_o <= 1'b1;
          end
          if (frame_start_i || to_hit) begin
            // A request in the apply cycle carries the newest data straight through
            for (int k = 0; k < NUM_REGS; k++) begin
              cfg_q[k] <= commit_req_i ? cfg_i[32*k +: 32] : stage_q[k];
            end
            state_q       <= DONE;
            commit_done_o <= 1'b1;
            commit_cnt_o  <= commit_cnt_o + 8'd1;
            if (!frame_start_i) begin
              timeout_o <= 1'b1;
            end
          end else if (commit_req_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              stage_q[k] <= cfg_i[32*k +: 32];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_config_commit_ctrl.sv
// tb/tb_sc_config_commit_ctrl.sv - self-checking bench for sc_config_commit_ctrl
module tb_sc_config_commit_ctrl;

  localparam int NR = 4;
  localparam int TO = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [32*NR-1:0] cfg_i = '0;
  logic             commit_req_i = 1'b0;
  logic             frame_start_i = 1'b0;
  logic [32*NR-1:0] cfg_o;
  logic             busy_o;
  logic             commit_done_o;
  logic             timeout_o;
  logic             coalesced_o;
  logic [7:0]       commit_cnt_o;

  sc_config_commit_ctrl #(
    .NUM_REGS       (NR),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (5)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cfg_i         (cfg_i),
    .commit_req_i  (commit_req_i),
    .frame_start_i (frame_start_i),
    .cfg_o         (cfg_o),
    .busy_o        (busy_o),
    .commit_done_o (commit_done_o),
    .timeout_o     (timeout_o),
    .coalesced_o   (coalesced_o),
    .commit_cnt_o  (commit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_fail  = 0;

  // Reference: a commit is "pending" from the request edge; it lands on the next
  // frame edge, or exactly TO edges after the request edge if no frame comes.
  int               cyc = 0;
  int               m_arm_edge;
  bit               m_pending;
  bit               m_done;
  bit               m_to;
  bit               m_coal;
  logic [7:0]       m_cnt;
  logic [32*NR-1:0] m_stage;
  logic [32*NR-1:0] m_cfg;

  function automatic logic [32*NR-1:0] w4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string tag, input logic [32*NR-1:0] obs, input logic [32*NR-1:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_done = 0; m_to = 0; m_coal = 0;
    m_cnt = '0; m_stage = '0; m_cfg = '0; m_arm_edge = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "/cfg"},  cfg_o,                m_cfg);
    check({tag, "/busy"}, 128'(busy_o),         128'(m_pending));
    check({tag, "/done"}, 128'(commit_done_o),  128'(m_done));
    check({tag, "/to"},   128'(timeout_o),      128'(m_to));
    check({tag, "/coal"}, 128'(coalesced_o),    128'(m_coal));
    check({tag, "/cnt"},  128'(commit_cnt_o),   128'(m_cnt));
  endtask

  // Drive one cycle of inputs at the falling edge, predict, clock, then compare
  task automatic step(input string tag, input logic r, input logic f, input logic [32*NR-1:0] c);
    int  e;
    bit  forced;
    commit_req_i  = r;
    frame_start_i = f;
    cfg_i         = c;
    e      = cyc + 1;
    m_done = 0;
    if (!m_pending) begin
      if (r) begin
        m_stage = c; m_pending = 1; m_arm_edge = e; m_to = 0; m_coal = 0;
      end
    end else begin
      forced = !f && (e - m_arm_edge == TO);
      if (r) m_coal = 1;
      if (f || forced) begin
        m_cfg     = r ? c : m_stage;
        m_pending = 0;
        m_done    = 1;
        m_cnt     = m_cnt + 8'd1;
        if (forced) m_to = 1;
      end else if (r) begin
        m_stage = c;
      end
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; commit_req_i = 1'b0; frame_start_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [32*NR-1:0] v;
    logic             r, f;

    model_reset();
    @(negedge clk_i);
    do_reset();
    check_model("reset");

    // 1: staged data without a request never reaches the datapath
    for (int i = 0; i < 5; i++) step("noreq", 0, 0, {4{32'hAAAA_5555}});
    check("noreq_cfg", cfg_o, '0);
    check("noreq_busy", 128'(busy_o), '0);
    check("noreq_cnt", 128'(commit_cnt_o), '0);

    // 2: snapshot at request, later cfg_i changes ignored, apply on frame start
    do_reset();
    for (int i = 0; i < 9; i++) step("pre", 0, 0, w4(1, 2, 3, 4));
    step("req", 1, 0, w4(1, 2, 3, 4));
    check("req_busy", 128'(busy_o), 128'(1));
    for (int i = 0; i < 3; i++) step("wait", 0, 0, w4(9, 9, 9, 9));
    check("wait_cfg_old", cfg_o, '0);
    step("fs", 0, 1, w4(9, 9, 9, 9));
    check("fs_cfg", cfg_o, w4(1, 2, 3, 4));
    check("fs_done", 128'(commit_done_o), 128'(1));
    check("fs_cnt", 128'(commit_cnt_o), 128'(1));
    check("fs_busy", 128'(busy_o), '0);
    step("post", 0, 0, w4(9, 9, 9, 9));
    check("post_done", 128'(commit_done_o), '0);

    // 3: request with simultaneous frame start only arms
    for (int i = 0; i < 3; i++) step("idle3", 0, 0, '0);
    step("reqfs", 1, 1, w4(32'h31, 32'h32, 32'h33, 32'h34));
    check("reqfs_busy", 128'(busy_o), 128'(1));
    check("reqfs_cfg", cfg_o, w4(1, 2, 3, 4));
    for (int i = 0; i < 10; i++) step("arm3", 0, 0, '0);
    step("fs3", 0, 1, '0);
    check("fs3_cfg", cfg_o, w4(32'h31, 32'h32, 32'h33, 32'h34));

    // 4: coalesced requests, newest data wins
    step("c_req1", 1, 0, w4(11, 12, 13, 14));
    step("c_req2", 1, 0, w4(5, 6, 7, 8));
    step("c_fs", 0, 1, '0);
    check("coal_cfg", cfg_o, w4(5, 6, 7, 8));
    check("coal_flag", 128'(coalesced_o), 128'(1));
    step("d_req1", 1, 0, w4(21, 22, 23, 24));
    step("d_reqfs", 1, 1, w4(41, 42, 43, 44));
    check("samecyc_cfg", cfg_o, w4(41, 42, 43, 44));

    // 5: timeout forces the apply after TO armed cycles
    step("t_req", 1, 0, w4(71, 72, 73, 74));
    for (int i = 0; i < TO - 1; i++) step("t_wait", 0, 0, '0);
    check("t_busy_last", 128'(busy_o), 128'(1));
    step("t_fire", 0, 0, '0);
    check("t_cfg", cfg_o, w4(71, 72, 73, 74));
    check("t_flag", 128'(timeout_o), 128'(1));
    step("t_clear", 1, 0, w4(81, 82, 83, 84));
    check("t_cleared", 128'(timeout_o), '0);
    step("t_fs", 0, 1, '0);

    // 6: counter wraps after 256 applies from reset
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step("w_req", 1, 0, 128'(i));
      step("w_fs", 0, 1, '0);
    end
    check("wrap_cnt", 128'(commit_cnt_o), '0);

    // asynchronous reset while armed drops the pending commit
    step("r_req", 1, 0, w4(1, 1, 1, 1));
    #2 rst_i = 1'b1;
    #1;
    check("rst_cfg", cfg_o, '0);
    check("rst_busy", 128'(busy_o), '0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check_model("rst_after");

    // randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 23) == 0);
      if (m_pending && (cyc + 1 - m_arm_edge == TO)) r = 1'b0;
      v = {$urandom, $urandom, $urandom, $urandom};
      step("rand", r, f, v);
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
